// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer in front of the single-port
// data memory. One access at a time: grant (IDLE), strobe (ACCESS), response
// strobe (RESP). Simultaneous requests are served round-robin by default.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins
// simultaneous requests; the round-robin pointer is removed.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [2:0]            m0_funct3,
    input  logic [DM_ADDRESS-1:0] m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [2:0]            m1_funct3,
    input  logic [DM_ADDRESS-1:0] m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [2:0]            mem_Funct3,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // Command registers not exposed on the memory pins (owner and direction).
    logic   cmd_id;
    logic   cmd_we;

    logic   gnt0;
    logic   gnt1;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Id of the requester granted most recently; the other one wins a tie.
    logic   last_id;
`endif

    // Combinational arbitration: grants only exist in IDLE, only to the winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                if (last_id) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
`endif
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign busy   = (state != IDLE);

    // Sequencer: latch the winner's command, strobe memory for one cycle,
    // then pulse the owner's response strobe. Memory pins hold the last command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_id       <= 1'b0;
            cmd_we       <= 1'b0;
            mem_Funct3   <= '0;
            mem_a        <= '0;
            mem_wd       <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            m0_rvalid    <= 1'b0;
            m1_rvalid    <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_id      <= 1'b1;
`endif
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        cmd_id       <= gnt1;
                        cmd_we       <= gnt1 ? m1_we : m0_we;
                        mem_Funct3   <= gnt1 ? m1_funct3 : m0_funct3;
                        mem_a        <= gnt1 ? m1_addr : m0_addr;
                        mem_wd       <= gnt1 ? m1_wdata : m0_wdata;
                        mem_MemWrite <= gnt1 ? m1_we : m0_we;
                        mem_MemRead  <= gnt1 ? ~m1_we : ~m0_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_id      <= gnt1;
`endif
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_MemWrite <= 1'b0;
                    mem_MemRead  <= 1'b0;
                    if (!cmd_we) begin
                        if (cmd_id) begin
                            m1_rdata <= mem_rd;
                        end else begin
                            m0_rdata <= mem_rd;
                        end
                    end
                    if (cmd_id) begin
                        m1_rvalid <= 1'b1;
                    end else begin
                        m0_rvalid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
